// File: rtl/axi_mem_pkg.sv
// Shared constants, FSM encodings and a clog2 helper for the AXI4 slave memory.
package axi_mem_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port (read-before-write).
module axi_mem_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);
    logic [DW-1:0] ram_array [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wstrb[b]) ram_array[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= ram_array[raddr];
    end
endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory with independent read/write FSMs, INCR bursts and strobes.
// Define AXI_SLAVE_MEM_WAIT_EN to insert C_WAIT_CYCLES wait states per beat.
module axi_slave_mem
    import axi_mem_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_OFFSET_WIDTH   = 28,
    parameter int C_ID_WIDTH       = 4,
    parameter int C_DEPTH          = 2048,
    parameter int C_WAIT_CYCLES    = 2
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic [C_ID_WIDTH-1:0]         AWID,
    input  logic [C_OFFSET_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                    AWLEN,
    input  logic [1:0]                    AWBURST,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                          WLAST,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [C_ID_WIDTH-1:0]         BID,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [C_ID_WIDTH-1:0]         ARID,
    input  logic [C_OFFSET_WIDTH-1:0]     ARADDR,
    input  logic [7:0]                    ARLEN,
    input  logic [1:0]                    ARBURST,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [C_ID_WIDTH-1:0]         RID,
    output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY
);
    localparam int BOFF   = clog2(C_AXI_DATA_WIDTH/8);
    localparam int IDX_W  = C_OFFSET_WIDTH - BOFF + 1;   // spare MSB so the index never wraps
    localparam int RAM_AW = (C_DEPTH > 1) ? clog2(C_DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(C_DEPTH);

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;
    logic [C_ID_WIDTH-1:0] w_id, r_id;
    logic [IDX_W-1:0] w_idx, r_idx;
    logic [7:0] w_len, w_cnt, r_len, r_cnt;
    logic w_ok, w_err, r_ok;
    logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld, rd_en;
    logic aw_hs, w_hs, ar_hs, r_hs, w_last_beat, r_last, r_beat_ok, w_beat_ok, w_beat_err;
    logic w_stall, r_stall;
    logic [C_AXI_DATA_WIDTH-1:0] ram_rdata;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{AWADDR[BOFF-1:0], ARADDR[BOFF-1:0]};

    assign aw_hs = AWREADY & AWVALID;
    assign w_hs  = WREADY & WVALID;
    assign ar_hs = ARREADY & ARVALID;
    assign r_hs  = RVALID & RREADY;

    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_ok   = w_ok && (w_idx < DEPTH_L);
    assign w_beat_err  = !w_beat_ok || (WLAST != w_last_beat);
    assign r_last      = (r_cnt == r_len);
    assign r_beat_ok   = r_ok && (r_idx < DEPTH_L);

`ifdef AXI_SLAVE_MEM_WAIT_EN
    localparam logic [7:0] WAITS = 8'(C_WAIT_CYCLES);
    logic [7:0] w_wait, r_wait;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            w_wait <= '0;
            r_wait <= '0;
        end else begin
            if (aw_hs || w_hs) w_wait <= WAITS;
            else if (w_wait != 8'd0) w_wait <= w_wait - 8'd1;
            if (ar_hs || (r_hs && !r_last)) r_wait <= WAITS;
            else if (r_state == R_WAIT && r_wait != 8'd0) r_wait <= r_wait - 8'd1;
        end
    end

    assign w_stall = (w_wait != 8'd0);
    assign r_stall = (r_wait != 8'd0);
`else
    assign w_stall = 1'b0;
    assign r_stall = 1'b0;
`endif

    always_comb begin
        w_state_nxt = w_state;
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        b_vld  = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_rdy = 1'b1;
                if (AWVALID) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_rdy = !w_stall;
                if (WVALID && w_rdy && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        ar_rdy = 1'b0;
        r_vld  = 1'b0;
        rd_en  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (ARVALID) r_state_nxt = R_WAIT;
            end
            R_WAIT: begin
                if (!r_stall) begin
                    rd_en       = r_beat_ok;
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (RREADY) r_state_nxt = r_last ? R_IDLE : R_WAIT;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            w_state <= W_IDLE;
            w_err   <= 1'b0;
            w_ok    <= 1'b0;
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_id  <= AWID;
                w_idx <= {1'b0, AWADDR[C_OFFSET_WIDTH-1:BOFF]};
                w_len <= AWLEN;
                w_cnt <= '0;
                w_ok  <= (AWBURST == BURST_INCR);
                w_err <= 1'b0;
            end else if (w_hs) begin
                w_idx <= w_idx + 1'b1;
                w_cnt <= w_cnt + 8'd1;
                if (w_beat_err) w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= R_IDLE;
            r_ok    <= 1'b0;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_id  <= ARID;
                r_idx <= {1'b0, ARADDR[C_OFFSET_WIDTH-1:BOFF]};
                r_len <= ARLEN;
                r_cnt <= '0;
                r_ok  <= (ARBURST == BURST_INCR);
            end else if (r_hs) begin
                r_idx <= r_idx + 1'b1;
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    axi_mem_ram #(
        .DW    (C_AXI_DATA_WIDTH),
        .DEPTH (C_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (CLK),
        .we    (w_hs && w_beat_ok),
        .waddr (w_idx[RAM_AW-1:0]),
        .wdata (WDATA),
        .wstrb (WSTRB),
        .re    (rd_en),
        .raddr (r_idx[RAM_AW-1:0]),
        .rdata (ram_rdata)
    );

    // Outputs are forced low while reset is held, not just after the first edge.
    assign AWREADY = RSTN & aw_rdy;
    assign WREADY  = RSTN & w_rdy;
    assign BVALID  = RSTN & b_vld;
    assign BID     = RSTN ? w_id : '0;
    assign BRESP   = (RSTN && w_err) ? RESP_SLVERR : RESP_OKAY;
    assign ARREADY = RSTN & ar_rdy;
    assign RVALID  = RSTN & r_vld;
    assign RID     = RSTN ? r_id : '0;
    assign RLAST   = RSTN & r_vld & r_last;
    assign RDATA   = (RSTN && r_vld && r_beat_ok) ? ram_rdata : '0;
    assign RRESP   = (RSTN && r_vld && !r_beat_ok) ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: stimulus pushes expected B/R responses, a monitor checks them.
module tb_axi_slave_mem;
    logic        CLK = 1'b0;
    logic        RSTN;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [27:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;

    typedef struct {logic [3:0] id; logic [1:0] resp;} b_exp_t;
    typedef struct {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; logic care;} r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];
    b_exp_t bm;
    r_exp_t rm;
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    axi_slave_mem u_dut (
        .CLK(CLK), .RSTN(RSTN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic exp_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                         input logic last, input logic care);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last; e.care = care;
        rq.push_back(e);
    endtask

    // Monitor: compare every handshaken B and R beat against the scoreboard queues.
    always @(negedge CLK) begin
        if (RSTN && BVALID && BREADY) begin
            if (bq.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: got bid=%h bresp=%h want none", BID, BRESP);
            end else begin
                bm = bq.pop_front();
                check("bid", 64'(BID), 64'(bm.id));
                check("bresp", 64'(BRESP), 64'(bm.resp));
            end
        end
        if (RSTN && RVALID && RREADY) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL r_unexpected: got rdata=%h want none", RDATA);
            end else begin
                rm = rq.pop_front();
                check("r_id_resp_last", {57'd0, RID, RRESP, RLAST}, {57'd0, rm.id, rm.resp, rm.last});
                if (rm.care) check("rdata", 64'(RDATA), 64'(rm.data));
            end
        end
    end

    task automatic do_write(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                            input logic bad_last, input logic [1:0] exp_resp,
                            output int w_lat, output int b_lat);
        int n;
        logic hs;
        b_exp_t e;
        e.id = id; e.resp = exp_resp;
        bq.push_back(e);
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin @(negedge CLK); hs = AWREADY; @(posedge CLK); #1; n++; end
        AWVALID = 1'b0;
        if (!hs) timeout("aw_handshake");
        w_lat = 0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = d0 + 32'(i); WSTRB = strb;
            WLAST = (i == int'(len)) ^ (bad_last && i == 0);
            WVALID = 1'b1;
            n = 0; hs = 1'b0;
            while (!hs && n < 50) begin @(negedge CLK); n++; hs = WREADY; @(posedge CLK); #1; end
            if (i == 0) w_lat = n;
            if (!hs) timeout("w_handshake");
        end
        WVALID = 1'b0; WLAST = 1'b0;
        b_lat = 0; hs = 1'b0;
        while (!hs && b_lat < 50) begin
            @(negedge CLK); hs = BVALID;
            @(posedge CLK); #1;
            if (!hs) b_lat++;
        end
        if (!hs) timeout("bvalid");
    endtask

    task automatic do_read(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic wait_done, output int lat);
        int n;
        logic hs;
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin @(negedge CLK); hs = ARREADY; @(posedge CLK); #1; n++; end
        ARVALID = 1'b0;
        if (!hs) timeout("ar_handshake");
        lat = 0; hs = 1'b0;
        while (!hs && lat < 50) begin
            @(negedge CLK); lat++; hs = RVALID;
            if (!hs) begin @(posedge CLK); #1; end
        end
        if (!hs) timeout("rvalid");
        if (wait_done) begin
            n = 0;
            while (rq.size() != 0 && n < 200) begin @(posedge CLK); #1; n++; end
            if (rq.size() != 0) timeout("read_drain");
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        int wl, bl, rl, wl2, bl2, rl2;
        logic [31:0] held;
        logic stable;
        RSTN = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", {59'd0, AWREADY, WREADY, BVALID, ARREADY, RVALID}, 64'd0);
        check("reset_rdata", 64'(RDATA), 64'd0);
        RSTN = 1'b1;
        @(posedge CLK); #1;
        check("idle_ready", {62'd0, AWREADY, ARREADY}, 64'd3);

        // single beat write/read with latency checks
        do_write(4'd3, 28'h10, 8'd0, 2'b01, 32'h3E800093, 4'hF, 1'b0, 2'b00, wl, bl);
        check("wready_latency", 64'(wl), 64'd1);
        check("bvalid_latency", 64'(bl), 64'd0);
        exp_r(4'd5, 32'h3E800093, 2'b00, 1'b1, 1'b1);
        do_read(4'd5, 28'h10, 8'd0, 2'b01, 1'b1, rl);
        check("rvalid_latency", 64'(rl), 64'd2);

        // 4-beat INCR burst
        do_write(4'd1, 28'h0, 8'd3, 2'b01, 32'd1, 4'hF, 1'b0, 2'b00, wl, bl);
        for (int i = 0; i < 4; i++) exp_r(4'd2, 32'(i + 1), 2'b00, i == 3, 1'b1);
        do_read(4'd2, 28'h0, 8'd3, 2'b01, 1'b1, rl);

        // byte strobes: bytes 0 and 2 replaced
        do_write(4'd0, 28'h20, 8'd0, 2'b01, 32'h11223344, 4'hF, 1'b0, 2'b00, wl, bl);
        do_write(4'd0, 28'h20, 8'd0, 2'b01, 32'hAABBCCDD, 4'b0101, 1'b0, 2'b00, wl, bl);
        exp_r(4'd7, 32'h11BB33DD, 2'b00, 1'b1, 1'b1);
        do_read(4'd7, 28'h20, 8'd0, 2'b01, 1'b1, rl);

        // last word in range then out of range
        do_write(4'd2, 28'h1FFC, 8'd0, 2'b01, 32'hCAFEF00D, 4'hF, 1'b0, 2'b00, wl, bl);
        exp_r(4'd9, 32'hCAFEF00D, 2'b00, 1'b0, 1'b1);
        exp_r(4'd9, 32'h0, 2'b10, 1'b1, 1'b1);
        do_read(4'd9, 28'h1FFC, 8'd1, 2'b01, 1'b1, rl);

        // non-INCR burst: SLVERR, RAM untouched
        do_write(4'd4, 28'h10, 8'd0, 2'b00, 32'hDEADBEEF, 4'hF, 1'b0, 2'b10, wl, bl);
        exp_r(4'd4, 32'h3E800093, 2'b00, 1'b1, 1'b1);
        do_read(4'd4, 28'h10, 8'd0, 2'b01, 1'b1, rl);
        exp_r(4'd6, 32'h0, 2'b10, 1'b0, 1'b0);
        exp_r(4'd6, 32'h0, 2'b10, 1'b1, 1'b0);
        do_read(4'd6, 28'h10, 8'd1, 2'b10, 1'b1, rl);

        // WLAST mismatch: SLVERR but data still written per AWLEN
        do_write(4'd8, 28'h30, 8'd1, 2'b01, 32'h55, 4'hF, 1'b1, 2'b10, wl, bl);
        exp_r(4'd8, 32'h55, 2'b00, 1'b0, 1'b1);
        exp_r(4'd8, 32'h56, 2'b00, 1'b1, 1'b1);
        do_read(4'd8, 28'h30, 8'd1, 2'b01, 1'b1, rl);

        // same-cycle read and write of one word returns the old data
        do_write(4'd1, 28'h40, 8'd0, 2'b01, 32'h0BADC0DE, 4'hF, 1'b0, 2'b00, wl, bl);
        exp_r(4'd3, 32'h0BADC0DE, 2'b00, 1'b1, 1'b1);
        fork
            do_write(4'd1, 28'h40, 8'd0, 2'b01, 32'h600DF00D, 4'hF, 1'b0, 2'b00, wl2, bl2);
            do_read(4'd3, 28'h40, 8'd0, 2'b01, 1'b1, rl2);
        join
        exp_r(4'd3, 32'h600DF00D, 2'b00, 1'b1, 1'b1);
        do_read(4'd3, 28'h40, 8'd0, 2'b01, 1'b1, rl);

        // RREADY stall for 10 cycles
        RREADY = 1'b0;
        for (int i = 0; i < 4; i++) exp_r(4'd5, 32'(i + 1), 2'b00, i == 3, 1'b1);
        do_read(4'd5, 28'h0, 8'd3, 2'b01, 1'b0, rl);
        held = RDATA; stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (!RVALID || RDATA !== held) stable = 1'b0;
        end
        check("stall_stable", {63'd0, stable}, 64'd1);
        check("stall_first_data", 64'(held), 64'd1);
        @(posedge CLK); #1;
        RREADY = 1'b1;
        for (int n = 0; n < 200 && rq.size() != 0; n++) begin @(posedge CLK); #1; end
        if (rq.size() != 0) timeout("stall_drain");

        // reset mid-burst: outputs drop, RAM preserved
        RREADY = 1'b0;
        do_read(4'd2, 28'h0, 8'd3, 2'b01, 1'b0, rl);
        @(posedge CLK); #1;
        RSTN = 1'b0;
        @(posedge CLK); #1;
        check("midreset_outputs", {59'd0, AWREADY, WREADY, BVALID, ARREADY, RVALID}, 64'd0);
        check("ram_preserved_1", 64'(u_dut.u_ram.ram_array[1]), 64'd2);
        check("ram_preserved_3", 64'(u_dut.u_ram.ram_array[3]), 64'd4);
        RSTN = 1'b1;
        RREADY = 1'b1;
        @(posedge CLK); #1;
        check("post_reset_ready", {62'd0, AWREADY, ARREADY}, 64'd3);
        exp_r(4'd1, 32'd1, 2'b00, 1'b1, 1'b1);
        do_read(4'd1, 28'h0, 8'd0, 2'b01, 1'b1, rl);

        check("b_queue_empty", 64'(bq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
